turn_around_pipe: RTL and testbench

TURN_AROUND_PIPE -- requirements
Module: turn_around_pipe

---
 rtl/turn_around_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_turn_around_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_around_pipe.sv
// -----------------------------------------------------------------------------
// turn_around_pipe
//
// Purpose:
//   Takes forward beats arriving on dirOneFront_*, decides once per packet
//   whether to admit or drop it, and sends admitted beats back out on
//   dirTwoBack_* after a fixed FWD_DEPTH-cycle register pipeline. Dropped and
//   idle beats leave the pipe as idle beats (Type 0). A separate BWD_DEPTH-stage
//   pipe delays backward instructions from dirTwoBack_Instruction* to
//   dirOneFront_Instruction*. Two counters track packets turned around and
//   packets dropped.
//
// Ports:
//   clk, rstnIn                   clock, asynchronous active-low reset
//   turnEnable                    admit new packets when 1 (sampled on the
//                                 first valid beat of each packet)
//   cntClear                      synchronous clear of both counters
//   dirOneFront_*                 incoming forward beat (Type 0 = idle)
//   dirTwoBack_*                  turned-around beat, FWD_DEPTH cycles later
//   dirTwoBack_Instruction*       incoming backward instruction
//   dirOneFront_Instruction*      backward instruction, BWD_DEPTH cycles later
//   fwdPktCount, dropPktCount     packets forwarded / dropped (wrapping)
//   inPacket                      1 while a multi-beat packet is in progress
// -----------------------------------------------------------------------------
module turn_around_pipe #(
    parameter int DATA_WIDTH                  = 512,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHUNK_ID_NUM                = 32,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int STATE_WIDTH                 = 32,
    parameter int INSTRUCTION_WIDTH           = 2,
    parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_IDLE = '0,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int FWD_DEPTH                   = 2,
    parameter int BWD_DEPTH                   = 2,
    parameter int COUNT_WIDTH                 = 32,
    localparam int STREAM_ID_WIDTH            = $clog2(STREAM_ID_NUM),
    localparam int CHUNK_ID_WIDTH             = $clog2(CHUNK_ID_NUM),
    localparam int CHANNEL_ID_WIDTH           = $clog2(CHANNEL_ID_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rstnIn,
    input  logic                                   turnEnable,
    input  logic                                   cntClear,

    input  logic [DATA_WIDTH-1:0]                  dirOneFront_Data,
    input  logic [1:0]                             dirOneFront_Type,
    input  logic                                   dirOneFront_Last,
    input  logic [STREAM_ID_WIDTH-1:0]             dirOneFront_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]              dirOneFront_ChunkID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            dirOneFront_ChannelID,
    input  logic [STATE_WIDTH-1:0]                 dirOneFront_State,

    output logic [DATA_WIDTH-1:0]                  dirTwoBack_Data,
    output logic [1:0]                             dirTwoBack_Type,
    output logic                                   dirTwoBack_Last,
    output logic [STREAM_ID_WIDTH-1:0]             dirTwoBack_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]              dirTwoBack_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0]            dirTwoBack_ChannelID,
    output logic [STATE_WIDTH-1:0]                 dirTwoBack_State,

    input  logic [INSTRUCTION_WIDTH-1:0]           dirTwoBack_InstructionType,
    input  logic [STREAM_ID_WIDTH-1:0]             dirTwoBack_InstructionStreamID,
    input  logic [CHANNEL_ID_WIDTH-1:0]            dirTwoBack_InstructionChannelID,
    input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirTwoBack_InstructionParameter,

    output logic [INSTRUCTION_WIDTH-1:0]           dirOneFront_InstructionType,
    output logic [STREAM_ID_WIDTH-1:0]             dirOneFront_InstructionStreamID,
    output logic [CHANNEL_ID_WIDTH-1:0]            dirOneFront_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dirOneFront_InstructionParameter,

    output logic [COUNT_WIDTH-1:0]                 fwdPktCount,
    output logic [COUNT_WIDTH-1:0]                 dropPktCount,
    output logic                                   inPacket
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD_PKT  = 2'd1,
        DROP_PKT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]       data;
        logic [1:0]                  typ;
        logic                        last;
        logic [STREAM_ID_WIDTH-1:0]  stream_id;
        logic [CHUNK_ID_WIDTH-1:0]   chunk_id;
        logic [CHANNEL_ID_WIDTH-1:0] channel_id;
        logic [STATE_WIDTH-1:0]      state;
    } fwd_beat_t;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0]           typ;
        logic [STREAM_ID_WIDTH-1:0]             stream_id;
        logic [CHANNEL_ID_WIDTH-1:0]            channel_id;
        logic [INSTRUCTION_PARAMETER_WIDTH-1:0] param;
    } bwd_instr_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_valid;
    logic       w_admit;
    logic       w_pass;
    logic       w_fwd_inc;
    logic       w_drop_inc;
    fwd_beat_t  w_beat_in;
    bwd_instr_t w_instr_in;

    fwd_beat_t  r_fwd [FWD_DEPTH];
    bwd_instr_t r_bwd [BWD_DEPTH];

    logic [COUNT_WIDTH-1:0] r_fwd_cnt;
    logic [COUNT_WIDTH-1:0] r_drop_cnt;

    assign w_valid = (dirOneFront_Type != 2'd0);

    // Gate decision and next state. In IDLE the decision comes straight from
    // turnEnable; inside a packet it is frozen by the state itself, so
    // turnEnable changes mid-packet are invisible.
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_admit      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            IDLE:     w_admit = turnEnable;
            FWD_PKT:  w_admit = 1'b1;
            DROP_PKT: w_admit = 1'b0;
            default:  w_admit = 1'b0;
        endcase
        if (w_valid) begin
            if (dirOneFront_Last) begin
                w_state_next = IDLE;
            end else if (r_state == IDLE) begin
                w_state_next = w_admit ? FWD_PKT : DROP_PKT;
            end
        end
    end

    assign w_pass     = w_valid && w_admit;
    assign w_fwd_inc  = w_pass && dirOneFront_Last;
    assign w_drop_inc = w_valid && !w_admit && dirOneFront_Last;

    // Non-admitted beats only need Type forced to 0; the remaining fields are
    // carried unchanged since nothing downstream looks at them.
    always_comb begin
        w_beat_in.data       = dirOneFront_Data;
        w_beat_in.typ        = w_pass ? dirOneFront_Type : 2'd0;
        w_beat_in.last       = dirOneFront_Last;
        w_beat_in.stream_id  = dirOneFront_StreamID;
        w_beat_in.chunk_id   = dirOneFront_ChunkID;
        w_beat_in.channel_id = dirOneFront_ChannelID;
        w_beat_in.state      = dirOneFront_State;
    end

    assign w_instr_in = '{typ:        dirTwoBack_InstructionType,
                          stream_id:  dirTwoBack_InstructionStreamID,
                          channel_id: dirTwoBack_InstructionChannelID,
                          param:      dirTwoBack_InstructionParameter};

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the pipeline stages are reset explicitly because a stale non-zero
    // Type left over from before reset would look like a real beat at the output.
    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                r_fwd[i] <= '0;
            end
        end else begin
            r_fwd[0] <= w_beat_in;
            for (int i = 1; i < FWD_DEPTH; i++) begin
                r_fwd[i] <= r_fwd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            for (int i = 0; i < BWD_DEPTH; i++) begin
                r_bwd[i]     <= '0;
                r_bwd[i].typ <= INSTRUCTION_CMD_IDLE;
            end
        end else begin
            r_bwd[0] <= w_instr_in;
            for (int i = 1; i < BWD_DEPTH; i++) begin
                r_bwd[i] <= r_bwd[i-1];
            end
        end
    end

    // Counters advance on the cycle the Last beat arrives, not when it leaves
    // the pipe. Clear has priority over a simultaneous increment.
    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (cntClear) begin
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_fwd_inc) begin
                r_fwd_cnt <= r_fwd_cnt + COUNT_WIDTH'(1);
            end
            if (w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    assign dirTwoBack_Data      = r_fwd[FWD_DEPTH-1].data;
    assign dirTwoBack_Type      = r_fwd[FWD_DEPTH-1].typ;
    assign dirTwoBack_Last      = r_fwd[FWD_DEPTH-1].last;
    assign dirTwoBack_StreamID  = r_fwd[FWD_DEPTH-1].stream_id;
    assign dirTwoBack_ChunkID   = r_fwd[FWD_DEPTH-1].chunk_id;
    assign dirTwoBack_ChannelID = r_fwd[FWD_DEPTH-1].channel_id;
    assign dirTwoBack_State     = r_fwd[FWD_DEPTH-1].state;

    assign dirOneFront_InstructionType      = r_bwd[BWD_DEPTH-1].typ;
    assign dirOneFront_InstructionStreamID  = r_bwd[BWD_DEPTH-1].stream_id;
    assign dirOneFront_InstructionChannelID = r_bwd[BWD_DEPTH-1].channel_id;
    assign dirOneFront_InstructionParameter = r_bwd[BWD_DEPTH-1].param;

    assign fwdPktCount  = r_fwd_cnt;
    assign dropPktCount = r_drop_cnt;
    assign inPacket     = (r_state != IDLE);

endmodule

// File: tb/tb_turn_around_pipe.sv
// -----------------------------------------------------------------------------
// tb_turn_around_pipe
//
// Directed bench for turn_around_pipe with FWD_DEPTH=3, BWD_DEPTH=2 and a
// 2-bit packet counter so wrap-around is reachable in a few packets.
// A vector table covers forwarding, dropping and the frozen gate decision;
// short hand-written sequences cover counter wrap/clear, the instruction
// delay and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_turn_around_pipe;

    localparam int DW  = 64;
    localparam int CW  = 2;
    localparam int SIW = 4;
    localparam int CIW = 5;
    localparam int CHW = 10;

    logic           clk = 1'b0;
    logic           rstnIn;
    logic           turnEnable;
    logic           cntClear;
    logic [DW-1:0]  in_data;
    logic [1:0]     in_type;
    logic           in_last;
    logic [SIW-1:0] in_sid;
    logic [CIW-1:0] in_cid;
    logic [CHW-1:0] in_chid;
    logic [31:0]    in_state;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_type;
    logic           out_last;
    logic [SIW-1:0] out_sid;
    logic [CIW-1:0] out_cid;
    logic [CHW-1:0] out_chid;
    logic [31:0]    out_state;
    logic [1:0]     ii_type;
    logic [SIW-1:0] ii_sid;
    logic [CHW-1:0] ii_chid;
    logic [15:0]    ii_param;
    logic [1:0]     io_type;
    logic [SIW-1:0] io_sid;
    logic [CHW-1:0] io_chid;
    logic [15:0]    io_param;
    logic [CW-1:0]  fwd_cnt;
    logic [CW-1:0]  drop_cnt;
    logic           in_pkt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    turn_around_pipe #(
        .DATA_WIDTH (DW),
        .FWD_DEPTH  (3),
        .BWD_DEPTH  (2),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk                             (clk),
        .rstnIn                          (rstnIn),
        .turnEnable                      (turnEnable),
        .cntClear                        (cntClear),
        .dirOneFront_Data                (in_data),
        .dirOneFront_Type                (in_type),
        .dirOneFront_Last                (in_last),
        .dirOneFront_StreamID            (in_sid),
        .dirOneFront_ChunkID             (in_cid),
        .dirOneFront_ChannelID           (in_chid),
        .dirOneFront_State               (in_state),
        .dirTwoBack_Data                 (out_data),
        .dirTwoBack_Type                 (out_type),
        .dirTwoBack_Last                 (out_last),
        .dirTwoBack_StreamID             (out_sid),
        .dirTwoBack_ChunkID              (out_cid),
        .dirTwoBack_ChannelID            (out_chid),
        .dirTwoBack_State                (out_state),
        .dirTwoBack_InstructionType      (ii_type),
        .dirTwoBack_InstructionStreamID  (ii_sid),
        .dirTwoBack_InstructionChannelID (ii_chid),
        .dirTwoBack_InstructionParameter (ii_param),
        .dirOneFront_InstructionType     (io_type),
        .dirOneFront_InstructionStreamID (io_sid),
        .dirOneFront_InstructionChannelID(io_chid),
        .dirOneFront_InstructionParameter(io_param),
        .fwdPktCount                     (fwd_cnt),
        .dropPktCount                    (drop_cnt),
        .inPacket                        (in_pkt)
    );

    typedef struct {
        logic        en;
        logic [1:0]  typ;
        logic        last;
        logic [15:0] data;
        logic [1:0]  exp_typ;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_inpkt;
        logic [1:0]  exp_fwd;
        logic [1:0]  exp_drop;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Side fields are derived from the data word so a forwarded beat can be
    // checked field by field from its data alone.
    task automatic drive_beat(input logic en, input logic [1:0] typ, input logic last, input logic [15:0] d);
        turnEnable = en;
        in_type    = typ;
        in_last    = last;
        in_data    = {48'h0, d};
        in_sid     = d[3:0];
        in_cid     = d[4:0];
        in_chid    = d[9:0];
        in_state   = {d, ~d};
    endtask

    task automatic drive_instr(input logic [1:0] t, input logic [SIW-1:0] s, input logic [CHW-1:0] c, input logic [15:0] p);
        ii_type  = t;
        ii_sid   = s;
        ii_chid  = c;
        ii_param = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out_beat(input string tag, input logic [1:0] t, input logic [15:0] d, input logic l);
        check({tag, ".type"}, 64'(out_type), 64'(t));
        if (t != 2'd0) begin
            check({tag, ".data"},    out_data,          {48'h0, d});
            check({tag, ".last"},    64'(out_last),     64'(l));
            check({tag, ".sid"},     64'(out_sid),      64'(d[3:0]));
            check({tag, ".chunk"},   64'(out_cid),      64'(d[4:0]));
            check({tag, ".channel"}, 64'(out_chid),     64'(d[9:0]));
            check({tag, ".state"},   64'(out_state),    64'({d, ~d}));
        end
    endtask

    initial begin
        // Each row: inputs applied before an edge, expectations observed just
        // after it. The output shows the row two earlier (three edges of delay).
        //          en  typ   last  data      etyp  edata     elast inpkt fwd   drop
        vecs[0]  = '{1'b1, 2'd1, 1'b0, 16'hA001, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 16'hA002, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[2]  = '{1'b1, 2'd1, 1'b0, 16'hA003, 2'd1, 16'hA001, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[3]  = '{1'b1, 2'd1, 1'b1, 16'hA004, 2'd1, 16'hA002, 1'b0, 1'b0, 2'd1, 2'd0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 16'hB001, 2'd1, 16'hA003, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 16'hB002, 2'd1, 16'hA004, 1'b1, 1'b1, 2'd1, 2'd0};
        vecs[6]  = '{1'b1, 2'd2, 1'b1, 16'hB003, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd1, 2'd1};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 16'hC001, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd1, 2'd1};
        vecs[8]  = '{1'b0, 2'd3, 1'b1, 16'hC002, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd1};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 16'hD001, 2'd3, 16'hC001, 1'b0, 1'b1, 2'd2, 2'd1};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 16'h0000, 2'd3, 16'hC002, 1'b1, 1'b1, 2'd2, 2'd1};
        vecs[11] = '{1'b1, 2'd1, 1'b1, 16'hD002, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd2};
        vecs[12] = '{1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd2};
        vecs[13] = '{1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd2};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd2};

        rstnIn   = 1'b0;
        cntClear = 1'b0;
        drive_beat(1'b0, 2'd0, 1'b0, 16'h0);
        drive_instr(2'd0, '0, '0, 16'h0);
        repeat (3) @(posedge clk);
        #3;
        rstnIn = 1'b1;
        #1;

        check("reset.out_type",   64'(out_type), 64'd0);
        check("reset.instr_type", 64'(io_type),  64'd0);
        check("reset.fwd_cnt",    64'(fwd_cnt),  64'd0);
        check("reset.drop_cnt",   64'(drop_cnt), 64'd0);
        check("reset.in_packet",  64'(in_pkt),   64'd0);

        tick();
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive_beat(vecs[i].en, vecs[i].typ, vecs[i].last, vecs[i].data);
            tick();
            check_out_beat(tag, vecs[i].exp_typ, vecs[i].exp_data, vecs[i].exp_last);
            check({tag, ".in_packet"}, 64'(in_pkt),   64'(vecs[i].exp_inpkt));
            check({tag, ".fwd_cnt"},   64'(fwd_cnt),  64'(vecs[i].exp_fwd));
            check({tag, ".drop_cnt"},  64'(drop_cnt), 64'(vecs[i].exp_drop));
        end

        // Counter wrap: forward count is 2, two more single-beat packets wrap it.
        drive_beat(1'b1, 2'd1, 1'b1, 16'h0E01);
        tick();
        check("wrap.fwd_3", 64'(fwd_cnt), 64'd3);
        drive_beat(1'b1, 2'd2, 1'b1, 16'h0E02);
        tick();
        check("wrap.fwd_0",  64'(fwd_cnt),  64'd0);
        check("wrap.drop_2", 64'(drop_cnt), 64'd2);

        // Clear wins over a coincident dropped Last beat.
        drive_beat(1'b0, 2'd1, 1'b1, 16'h0E03);
        cntClear = 1'b1;
        tick();
        cntClear = 1'b0;
        check("clear.drop", 64'(drop_cnt), 64'd0);
        check("clear.fwd",  64'(fwd_cnt),  64'd0);

        // Clear wins over a coincident admitted Last beat.
        drive_beat(1'b1, 2'd1, 1'b1, 16'h0E04);
        tick();
        check("clear.fwd_pre", 64'(fwd_cnt), 64'd1);
        drive_beat(1'b1, 2'd1, 1'b1, 16'h0E05);
        cntClear = 1'b1;
        tick();
        cntClear = 1'b0;
        check("clear.fwd_post", 64'(fwd_cnt), 64'd0);
        drive_beat(1'b0, 2'd0, 1'b0, 16'h0);

        // Backward instruction: one-cycle pulse reappears two edges later.
        drive_instr(2'd2, 4'd5, 10'h155, 16'h1234);
        tick();
        drive_instr(2'd0, '0, '0, 16'h0);
        check("instr.edge1_type", 64'(io_type), 64'd0);
        tick();
        check("instr.edge2_type",    64'(io_type),  64'd2);
        check("instr.edge2_param",   64'(io_param), 64'h1234);
        check("instr.edge2_sid",     64'(io_sid),   64'd5);
        check("instr.edge2_channel", 64'(io_chid),  64'h155);
        tick();
        check("instr.edge3_type",  64'(io_type),  64'd0);
        check("instr.edge3_param", 64'(io_param), 64'd0);

        // Reset during beat 2 of a 4-beat packet.
        drive_beat(1'b1, 2'd1, 1'b1, 16'h0F01);
        drive_instr(2'd3, 4'd9, 10'h2AA, 16'hBEEF);
        tick();
        check("rst.pre_fwd", 64'(fwd_cnt), 64'd1);
        drive_beat(1'b1, 2'd1, 1'b0, 16'h0F02);
        tick();
        check("rst.pre_in_packet",  64'(in_pkt),  64'd1);
        check("rst.pre_instr_type", 64'(io_type), 64'd3);
        drive_beat(1'b1, 2'd1, 1'b0, 16'h0F03);
        rstnIn = 1'b0;
        #1;
        check("rst.out_type",   64'(out_type), 64'd0);
        check("rst.instr_type", 64'(io_type),  64'd0);
        check("rst.fwd_cnt",    64'(fwd_cnt),  64'd0);
        check("rst.drop_cnt",   64'(drop_cnt), 64'd0);
        check("rst.in_packet",  64'(in_pkt),   64'd0);
        drive_instr(2'd0, '0, '0, 16'h0);
        #2;
        rstnIn = 1'b1;

        // First beat after release starts a new packet; turnEnable=0 drops it.
        drive_beat(1'b0, 2'd1, 1'b0, 16'h0F04);
        tick();
        check("post.in_packet", 64'(in_pkt),   64'd1);
        check("post.fwd_cnt",   64'(fwd_cnt),  64'd0);
        drive_beat(1'b1, 2'd1, 1'b1, 16'h0F05);
        tick();
        check("post.drop_cnt",   64'(drop_cnt), 64'd1);
        check("post.fwd_cnt2",   64'(fwd_cnt),  64'd0);
        check("post.in_packet2", 64'(in_pkt),   64'd0);
        drive_beat(1'b0, 2'd0, 1'b0, 16'h0);
        tick();
        check("post.out_beat1", 64'(out_type), 64'd0);
        tick();
        check("post.out_beat2", 64'(out_type), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
